// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and flush controller for the 5-stage pipeline.
// Shadows rd/control of in-flight instructions to drive stalls, flushes and forward selects.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W   = 5,
  parameter int CNT_W        = 32,
  parameter int BRANCH_STAGE = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  br_taken,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  flush_ifid,
  output logic                  flush_idex,
  output logic                  flush_exmem,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  memread;
  } SlotT;

  localparam logic BranchInMem = (BRANCH_STAGE == 3);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  SlotT exSlot, memSlot, wbSlot;
  logic luse, fl, enterEx;
  logic [1:0] fwdANext, fwdBNext;

  // The WB slot is tracked but never consulted: the register file writes before it reads.
  logic unusedSlotBits;
  assign unusedSlotBits = ^{wbSlot, memSlot.memread};

  function automatic logic slotWrites(SlotT s, logic [REG_ADDR_W-1:0] r);
    return s.valid && s.regwrite && (s.rd == r) && (r != '0);
  endfunction

  // Younger producer (currently in EX, headed for MEM) takes priority.
  function automatic logic [1:0] fwdSel(SlotT ex, SlotT mem, logic [REG_ADDR_W-1:0] r,
                                        logic uses);
    logic [1:0] sel;
    sel = 2'b00;
    if (uses) begin
      if (slotWrites(ex, r))       sel = 2'b10;
      else if (slotWrites(mem, r)) sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    luse        = 1'b0;
    fl          = 1'b0;
    enterEx     = 1'b0;
    fwdANext    = 2'b00;
    fwdBNext    = 2'b00;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    if (!reset) begin
      luse = id_valid && exSlot.valid && exSlot.memread && (exSlot.rd != '0) &&
             ((id_uses_rs1 && (id_rs1 == exSlot.rd)) ||
              (id_uses_rs2 && (id_rs2 == exSlot.rd)));
      fl          = br_taken;
      enterEx     = id_valid && !luse && !fl;
      pc_en       = !luse || fl;
      ifid_en     = !luse || fl;
      flush_ifid  = fl;
      flush_idex  = fl || luse;
      flush_exmem = fl && BranchInMem;
      if (enterEx) begin
        fwdANext = fwdSel(exSlot, memSlot, id_rs1, id_uses_rs1);
        fwdBNext = fwdSel(exSlot, memSlot, id_rs2, id_uses_rs2);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exSlot    <= '0;
      memSlot   <= '0;
      wbSlot    <= '0;
      fwd_a     <= 2'b00;
      fwd_b     <= 2'b00;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      exSlot <= '{valid: enterEx, rd: id_rd, regwrite: id_regwrite, memread: id_memread};
      if (fl && BranchInMem) memSlot <= '0;
      else                   memSlot <= exSlot;
      wbSlot <= memSlot;
      fwd_a  <= fwdANext;
      fwd_b  <= fwdBNext;
      if (luse && !fl && (stall_cnt != CntMax)) stall_cnt <= stall_cnt + 1'b1;
      if (fl && (flush_cnt != CntMax))          flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (branch in MEM with 4-bit counters, branch in EX
// with 32-bit counters) share stimulus and are compared against an in-flight instruction model.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, idValid, idUsesRs1, idUsesRs2, idRegwrite, idMemread, brTaken;
  logic [4:0] idRs1, idRs2, idRd;

  logic       pcEn [2];
  logic       ifidEn [2];
  logic       flushIfid [2];
  logic       flushIdex [2];
  logic       flushExmem [2];
  logic [1:0] fwdA [2];
  logic [1:0] fwdB [2];
  logic [3:0]  stallCnt0, flushCnt0;
  logic [31:0] stallCnt1, flushCnt1;

  int errors = 0;
  int checks = 0;

  pipe_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(4), .BRANCH_STAGE(3)) dutMem (
    .clk(clk), .reset(reset), .id_valid(idValid), .id_rs1(idRs1), .id_rs2(idRs2),
    .id_uses_rs1(idUsesRs1), .id_uses_rs2(idUsesRs2), .id_rd(idRd),
    .id_regwrite(idRegwrite), .id_memread(idMemread), .br_taken(brTaken),
    .pc_en(pcEn[0]), .ifid_en(ifidEn[0]), .flush_ifid(flushIfid[0]),
    .flush_idex(flushIdex[0]), .flush_exmem(flushExmem[0]),
    .fwd_a(fwdA[0]), .fwd_b(fwdB[0]), .stall_cnt(stallCnt0), .flush_cnt(flushCnt0));

  pipe_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(32), .BRANCH_STAGE(2)) dutEx (
    .clk(clk), .reset(reset), .id_valid(idValid), .id_rs1(idRs1), .id_rs2(idRs2),
    .id_uses_rs1(idUsesRs1), .id_uses_rs2(idUsesRs2), .id_rd(idRd),
    .id_regwrite(idRegwrite), .id_memread(idMemread), .br_taken(brTaken),
    .pc_en(pcEn[1]), .ifid_en(ifidEn[1]), .flush_ifid(flushIfid[1]),
    .flush_idex(flushIdex[1]), .flush_exmem(flushExmem[1]),
    .fwd_a(fwdA[1]), .fwd_b(fwdB[1]), .stall_cnt(stallCnt1), .flush_cnt(flushCnt1));

  // Model: per instance, the instructions currently past ID, youngest first (EX, MEM, WB).
  typedef struct {
    bit       valid;
    bit [4:0] rd;
    bit       regwrite;
    bit       memread;
  } InFlight;

  InFlight         inFlight [2][3];
  logic [63:0]     expFwdA [2];
  logic [63:0]     expFwdB [2];
  longint unsigned expStall [2];
  longint unsigned expFlush [2];
  int              branchStage [2] = '{3, 2};
  longint unsigned cntMax [2] = '{64'd15, 64'hFFFF_FFFF};

  function automatic bit producerHits(InFlight p, bit [4:0] r);
    return p.valid && p.regwrite && (p.rd == r) && (r != 5'd0);
  endfunction

  function automatic bit loadUse(int d);
    InFlight ex;
    ex = inFlight[d][0];
    if (!idValid || !ex.valid || !ex.memread || ex.rd == 5'd0) return 1'b0;
    return (idUsesRs1 && idRs1 == ex.rd) || (idUsesRs2 && idRs2 == ex.rd);
  endfunction

  function automatic logic [63:0] expectSel(int d, bit [4:0] r, bit uses);
    if (!uses) return 64'd0;
    if (producerHits(inFlight[d][0], r)) return 64'd2;
    if (producerHits(inFlight[d][1], r)) return 64'd1;
    return 64'd0;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive ID/branch inputs, check combinational outputs, advance, check registers.
  task automatic applyStimulus(input int rst, input int v, input int rs1, input int rs2,
                               input int u1, input int u2, input int rd, input int rw,
                               input int mr, input int br);
    bit lu, f, enter;
    reset = 1'(rst); idValid = 1'(v); idRs1 = 5'(rs1); idRs2 = 5'(rs2);
    idUsesRs1 = 1'(u1); idUsesRs2 = 1'(u2); idRd = 5'(rd);
    idRegwrite = 1'(rw); idMemread = 1'(mr); brTaken = 1'(br);
    #1;
    for (int d = 0; d < 2; d++) begin
      lu = !reset && loadUse(d);
      f  = !reset && brTaken;
      checkOutput($sformatf("pc_en[%0d]", d), 64'(pcEn[d]), 64'(!lu || f));
      checkOutput($sformatf("ifid_en[%0d]", d), 64'(ifidEn[d]), 64'(!lu || f));
      checkOutput($sformatf("flush_ifid[%0d]", d), 64'(flushIfid[d]), 64'(f));
      checkOutput($sformatf("flush_idex[%0d]", d), 64'(flushIdex[d]), 64'(f || lu));
      checkOutput($sformatf("flush_exmem[%0d]", d), 64'(flushExmem[d]),
                  64'(f && branchStage[d] == 3));
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        for (int s = 0; s < 3; s++) inFlight[d][s] = '{default: 0};
        expFwdA[d] = 0; expFwdB[d] = 0; expStall[d] = 0; expFlush[d] = 0;
      end else begin
        lu    = loadUse(d);
        f     = brTaken;
        enter = idValid && !lu && !f;
        expFwdA[d] = enter ? expectSel(d, idRs1, idUsesRs1) : 64'd0;
        expFwdB[d] = enter ? expectSel(d, idRs2, idUsesRs2) : 64'd0;
        if (lu && !f && expStall[d] < cntMax[d]) expStall[d]++;
        if (f && expFlush[d] < cntMax[d]) expFlush[d]++;
        inFlight[d][2] = inFlight[d][1];
        if (f && branchStage[d] == 3) inFlight[d][1] = '{default: 0};
        else inFlight[d][1] = inFlight[d][0];
        if (enter) inFlight[d][0] = '{valid: 1, rd: idRd, regwrite: idRegwrite, memread: idMemread};
        else inFlight[d][0] = '{default: 0};
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("fwd_a[%0d]", d), 64'(fwdA[d]), expFwdA[d]);
      checkOutput($sformatf("fwd_b[%0d]", d), 64'(fwdB[d]), expFwdB[d]);
    end
    checkOutput("stall_cnt[0]", 64'(stallCnt0), expStall[0]);
    checkOutput("flush_cnt[0]", 64'(flushCnt0), expFlush[0]);
    checkOutput("stall_cnt[1]", 64'(stallCnt1), expStall[1]);
    checkOutput("flush_cnt[1]", 64'(flushCnt1), expFlush[1]);
    @(negedge clk);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 3; s++) inFlight[d][s] = '{default: 0};
      expFwdA[d] = 0; expFwdB[d] = 0; expStall[d] = 0; expFlush[d] = 0;
    end
    // Arguments: reset, valid, rs1, rs2, usesRs1, usesRs2, rd, regwrite, memread, brTaken
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 3, 3, 1, 1, 3, 1, 1, 1);
    checkOutput("reset stall_cnt", 64'(stallCnt1), 64'd0);
    checkOutput("reset fwd_a", 64'(fwdA[0]), 64'd0);

    // ld x5 ; add x6,x5,x7 stalls once, then forwards the load from MEM/WB
    applyStimulus(0, 1, 0, 0, 0, 0, 5, 1, 1, 0);
    applyStimulus(0, 1, 5, 7, 1, 1, 6, 1, 0, 0);
    checkOutput("load-use stall_cnt", 64'(stallCnt1), 64'd1);
    applyStimulus(0, 1, 5, 7, 1, 1, 6, 1, 0, 0);
    checkOutput("load-use fwd_a", 64'(fwdA[1]), 64'd1);

    // add x5 ; sub x8,x5,x5 forwards both operands from EX/MEM
    applyStimulus(0, 1, 1, 2, 1, 1, 5, 1, 0, 0);
    applyStimulus(0, 1, 5, 5, 1, 1, 8, 1, 0, 0);
    checkOutput("ex forward fwd_b", 64'(fwdB[0]), 64'd2);

    // add x5 ; nop ; or x9,x5,x0 then add x0 ; use x0
    applyStimulus(0, 1, 1, 2, 1, 1, 5, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 5, 0, 1, 1, 9, 1, 0, 0);
    applyStimulus(0, 1, 1, 2, 1, 1, 0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 1, 1, 10, 1, 0, 0);

    // Taken branch, then branch colliding with a load-use, then back-to-back branches
    applyStimulus(0, 1, 1, 2, 1, 1, 11, 1, 0, 1);
    checkOutput("first flush_cnt", 64'(flushCnt0), 64'd1);
    applyStimulus(0, 1, 0, 0, 0, 0, 5, 1, 1, 0);
    applyStimulus(0, 1, 5, 7, 1, 1, 6, 1, 0, 1);
    applyStimulus(0, 1, 5, 7, 1, 1, 6, 1, 0, 1);
    applyStimulus(0, 1, 5, 7, 1, 1, 6, 1, 0, 0);

    // 20 load-use pairs saturate the 4-bit stall counter
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 1, 0, 0, 0, 0, 5, 1, 1, 0);
      applyStimulus(0, 1, 0, 5, 0, 1, 6, 1, 0, 0);
      applyStimulus(0, 1, 0, 5, 0, 1, 6, 1, 0, 0);
    end
    checkOutput("saturated stall_cnt", 64'(stallCnt0), 64'd15);

    // Reset in the middle of a stall leaves nothing behind
    applyStimulus(0, 1, 0, 0, 0, 0, 7, 1, 1, 0);
    applyStimulus(1, 1, 7, 0, 1, 0, 8, 1, 0, 0);
    applyStimulus(0, 1, 7, 0, 1, 0, 8, 1, 0, 0);
    checkOutput("post-reset stall_cnt", 64'(stallCnt0), 64'd0);

    // Random traffic over a small register range to provoke hazards
    for (int i = 0; i < 500; i++) begin
      applyStimulus(int'($urandom_range(0, 59) == 0), int'($urandom_range(0, 5) != 0),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 1)), int'($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
